// File: rtl/perceptron_sample_sequencer.sv
// Loads a small training set byte-serially, then streams (x0, x1, y) samples to a
// perceptron trainer epoch after epoch until an error-free epoch or the epoch limit.
module perceptron_sample_sequencer #(
    parameter int NUM_SAMPLES = 3,
    parameter int DATA_W      = 8,
    parameter int MAX_EPOCHS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              start,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [DATA_W-1:0] smp_x0,
    output logic [DATA_W-1:0] smp_x1,
    output logic              smp_y,
    output logic [3:0]        smp_idx,
    output logic              smp_last,
    input  logic              err_valid,
    input  logic              err,
    output logic [7:0]        epoch_count,
    output logic              busy,
    output logic              done,
    output logic              converged
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_SAMPLES - 1);
    localparam logic [4:0] NS_CNT   = 5'(NUM_SAMPLES);
    localparam logic [7:0] MAX_EP   = 8'(MAX_EPOCHS);

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_STREAM    = 3'd2,
        ST_EPOCH_END = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        idx_r, idx_s;
    logic [7:0]        epoch_cnt_r, epoch_cnt_s;
    logic [4:0]        err_cnt_r, err_cnt_s;
    logic              epoch_err_r, epoch_err_s;
    logic              converged_r, converged_s;
    logic [3:0]        ld_smp_r, ld_smp_s;
    logic [1:0]        ld_fld_r, ld_fld_s;
    logic              ld_wr_s;
    logic              hs_s;

    logic [DATA_W-1:0] x0_mem [0:15];
    logic [DATA_W-1:0] x1_mem [0:15];
    logic              y_mem  [0:15];

    logic              load_ready_r;
    logic              smp_valid_r;
    logic [DATA_W-1:0] smp_x0_r;
    logic [DATA_W-1:0] smp_x1_r;
    logic              smp_y_r;
    logic [3:0]        smp_idx_r;
    logic              smp_last_r;
    logic              busy_r;
    logic              done_r;

    // Next-state, sample pointer, error tally and load counter logic.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        epoch_cnt_s = epoch_cnt_r;
        err_cnt_s   = err_cnt_r;
        epoch_err_s = epoch_err_r;
        converged_s = converged_r;
        ld_smp_s    = ld_smp_r;
        ld_fld_s    = ld_fld_r;
        ld_wr_s     = 1'b0;
        hs_s        = smp_valid_r & smp_ready;

        // A report arriving in the same cycle as the epoch-end decision is counted first.
        if (err_valid && (state_r == ST_STREAM || state_r == ST_EPOCH_END) &&
            (err_cnt_r < NS_CNT)) begin
            err_cnt_s   = err_cnt_r + 5'd1;
            epoch_err_s = epoch_err_r | err;
        end else begin
            err_cnt_s   = err_cnt_r;
            epoch_err_s = epoch_err_r;
        end

        case (state_r)
            ST_LOAD: begin
                if (load_valid && load_ready_r) begin
                    ld_wr_s = 1'b1;
                    if (ld_fld_r == 2'd2) begin
                        ld_fld_s = 2'd0;
                        if (ld_smp_r == LAST_IDX) begin
                            ld_smp_s = 4'd0;
                            state_s  = ST_WAIT;
                        end else begin
                            ld_smp_s = ld_smp_r + 4'd1;
                        end
                    end else begin
                        ld_fld_s = ld_fld_r + 2'd1;
                    end
                end else begin
                    ld_wr_s = 1'b0;
                end
            end
            ST_WAIT, ST_DONE: begin
                if (start) begin
                    state_s     = ST_STREAM;
                    idx_s       = 4'd0;
                    epoch_cnt_s = 8'd1;
                    err_cnt_s   = 5'd0;
                    epoch_err_s = 1'b0;
                    converged_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_STREAM: begin
                if (hs_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_EPOCH_END;
                    end else begin
                        idx_s = idx_r + 4'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_EPOCH_END: begin
                if (err_cnt_s == NS_CNT) begin
                    if (!epoch_err_s) begin
                        state_s     = ST_DONE;
                        converged_s = 1'b1;
                    end else if (epoch_cnt_r == MAX_EP) begin
                        state_s     = ST_DONE;
                        converged_s = 1'b0;
                    end else begin
                        state_s     = ST_STREAM;
                        epoch_cnt_s = epoch_cnt_r + 8'd1;
                        idx_s       = 4'd0;
                        err_cnt_s   = 5'd0;
                        epoch_err_s = 1'b0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            idx_r       <= 4'd0;
            epoch_cnt_r <= 8'd0;
            err_cnt_r   <= 5'd0;
            epoch_err_r <= 1'b0;
            converged_r <= 1'b0;
            ld_smp_r    <= 4'd0;
            ld_fld_r    <= 2'd0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            epoch_cnt_r <= epoch_cnt_s;
            err_cnt_r   <= err_cnt_s;
            epoch_err_r <= epoch_err_s;
            converged_r <= converged_s;
            ld_smp_r    <= ld_smp_s;
            ld_fld_r    <= ld_fld_s;
        end
    end

    // Training-set buffer: not reset, written only while loading.
    always_ff @(posedge clk) begin
        if (ld_wr_s && !rst) begin
            case (ld_fld_r)
                2'd0:    x0_mem[ld_smp_r] <= load_data;
                2'd1:    x1_mem[ld_smp_r] <= load_data;
                2'd2:    y_mem[ld_smp_r]  <= load_data[0];
                default: y_mem[ld_smp_r]  <= y_mem[ld_smp_r];
            endcase
        end
    end

    // Output registers, derived from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ready_r <= 1'b1;
            smp_valid_r  <= 1'b0;
            smp_x0_r     <= {DATA_W{1'b0}};
            smp_x1_r     <= {DATA_W{1'b0}};
            smp_y_r      <= 1'b0;
            smp_idx_r    <= 4'd0;
            smp_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            load_ready_r <= (state_s == ST_LOAD);
            smp_valid_r  <= (state_s == ST_STREAM);
            smp_x0_r     <= (state_s == ST_STREAM) ? x0_mem[idx_s] : {DATA_W{1'b0}};
            smp_x1_r     <= (state_s == ST_STREAM) ? x1_mem[idx_s] : {DATA_W{1'b0}};
            smp_y_r      <= (state_s == ST_STREAM) ? y_mem[idx_s] : 1'b0;
            smp_idx_r    <= (state_s == ST_STREAM) ? idx_s : 4'd0;
            smp_last_r   <= (state_s == ST_STREAM) && (idx_s == LAST_IDX);
            busy_r       <= (state_s == ST_STREAM) || (state_s == ST_EPOCH_END);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign load_ready  = load_ready_r;
    assign smp_valid   = smp_valid_r;
    assign smp_x0      = smp_x0_r;
    assign smp_x1      = smp_x1_r;
    assign smp_y       = smp_y_r;
    assign smp_idx     = smp_idx_r;
    assign smp_last    = smp_last_r;
    assign epoch_count = epoch_cnt_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign converged   = converged_r;

endmodule

// File: doc/perceptron_sample_sequencer.md
Name: perceptron_sample_sequencer

Overview:
Upstream feeder for the perceptron training stage. It loads a small training set byte-serially into an internal buffer, then streams (x0, x1, y) samples to the trainer over a valid/ready handshake, epoch after epoch. It collects one per-sample error flag back from the trainer and stops on convergence (an error-free epoch) or when the epoch limit is reached.

Parameters:
NUM_SAMPLES, 3, number of training samples held (2..16)
DATA_W, 8, width of x0/x1 and of load bytes (signed two's complement)
MAX_EPOCHS, 16, epoch limit before giving up (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
load_valid  in  1  load byte present
load_data  in  DATA_W  load byte; per sample the order is x0, x1, y (y = bit 0 only)
load_ready  out  1  high only in LOAD
start  in  1  one-cycle pulse; begins training from WAIT_START or DONE
smp_valid  out  1  sample presented to trainer
smp_ready  in  1  trainer accepts sample
smp_x0  out  DATA_W  feature 0
smp_x1  out  DATA_W  feature 1
smp_y  out  1  label
smp_idx  out  4  sample index
smp_last  out  1  high with the last sample of an epoch
err_valid  in  1  trainer reports the result for one sample, in acceptance order
err  in  1  1 = prediction mismatched label
epoch_count  out  8  epochs started in the current run
busy  out  1  high in STREAM/EPOCH_END
done  out  1  high in DONE
converged  out  1  valid when done; 1 = last epoch error-free

Behaviour:
- Reset: state=LOAD, all outputs 0 except load_ready=1. Buffer contents undefined, not cleared. Reset mid-operation aborts any run immediately; no handshake is completed in the reset cycle.
- LOAD: each cycle with load_valid & load_ready writes load_data to slot (byte_cnt/3, byte_cnt%3). byte_cnt increments from 0 to 3*NUM_SAMPLES-1. On accepting the final byte -> WAIT_START next cycle, with load_ready low from that cycle on. start is ignored in LOAD.
- WAIT_START: idle. On start -> STREAM with idx=0, epoch_count=1, err_cnt=0, epoch_err=0.
- STREAM: smp_valid=1 with the buffered sample at idx. The outputs are registered and driven from buffer[idx]. They hold stable while smp_ready is low.
  - A handshake (valid & ready) advances idx by 1, so back-to-back acceptance gives 1 sample per cycle.
  - smp_last = (idx == NUM_SAMPLES-1).
  - A handshake on the last sample -> EPOCH_END, with smp_valid low the next cycle.
- Error collection, independent of state in STREAM and EPOCH_END: each err_valid increments err_cnt and ORs err into epoch_err.
  - err_valid in the same cycle as a handshake is legal and counted.
  - err_valid outside STREAM/EPOCH_END is ignored.
  - err_cnt never exceeds NUM_SAMPLES; any extra pulses are ignored.
- EPOCH_END: wait until err_cnt == NUM_SAMPLES, including a pulse arriving that same cycle, which is counted first. Then:
  - epoch_err==0 -> DONE, converged=1.
  - else if epoch_count == MAX_EPOCHS -> DONE, converged=0.
  - else epoch_count+1, idx=0, err_cnt=0, epoch_err=0 -> STREAM.
- DONE: done=1; converged and epoch_count hold.
  - start -> new run on the same buffer: epoch_count=1, converged=0.
  - To reload data, assert rst.
- busy = state in {STREAM, EPOCH_END}. Exactly one of load_ready/busy/done is high, or none (WAIT_START).
- Widths: epoch_count is 8 bits and saturates naturally by the MAX_EPOCHS ≤ 255 limit; it never wraps. x values pass through unmodified; y = load_data[0].

Test Plan:
- Load bytes 02,03,00, 04,05,01, 04,05,01 with load_valid held high -> load_ready deasserts after the 9th byte; start; smp_ready=1 -> samples idx 0,1,2 on 3 consecutive cycles with x0/x1/y = 02/03/0, 04/05/1, 04/05/1; smp_last only on idx 2.
- Backpressure: smp_ready toggled 0,0,1 per sample -> outputs stable while stalled; each sample accepted exactly once.
- Epoch 1 errors 0,1,0, epoch 2 errors 0,0,0 -> second epoch streamed, then done=1, converged=1, epoch_count=2.
- MAX_EPOCHS=2 with err=1 every sample -> done=1, converged=0, epoch_count=2, no third epoch.
- Last err_valid arrives 5 cycles after the last handshake, and one err_valid coincides with a handshake -> stays in EPOCH_END until the 3rd report; counts correct.
- Assert rst mid-STREAM at idx 1 -> next cycle smp_valid=0, load_ready=1, epoch_count=0; start in this state is ignored.
